// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store bus arbiter:
// FSM state encoding, starvation counter width and its default limit.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_PEND = 2'd1,
    LS_PEND = 2'd2,
    IF_DROP = 2'd3
  } arb_state_t;

  // Default number of back-to-back LSU grants allowed while a fetch waits.
  localparam int STARVE_MAX_DEFAULT = 4;

  // Width of the starvation counter; STARVE_MAX must fit in it.
  localparam int STARVE_W = 3;

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational requester selection. The LSU wins while the fetch side has
// not yet been starved; once the limit is reached a live (non-flushed) fetch
// wins, and the LSU still gets the bus if the fetch side is not asking.
module bus_arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                if_req,
  input  logic                if_flush,
  input  logic                ls_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                sel_if,
  output logic                sel_ls
);

  logic ls_first;

  assign ls_first = ls_req && (starve_cnt < STARVE_W'(STARVE_MAX));
  assign sel_if   = !ls_first && if_req && !if_flush;
  assign sel_ls   = ls_first || (!sel_if && ls_req);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch and
// load/store. Only one bus transaction is ever outstanding. A fetch flushed
// while in flight is tracked until its response arrives and then dropped.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [31:0]       i_ls_wdata,
  input  logic [3:0]        i_ls_wstrb,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [31:0]       o_ls_rdata,
  output logic              o_ls_busy,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_wstrb,
  input  logic              i_bus_gnt,
  input  logic              i_bus_rvalid,
  input  logic [31:0]       i_bus_rdata
);

  arb_state_t          state_reg;
  logic [STARVE_W-1:0] starve_cnt_reg;
  logic                sel_if;
  logic                sel_ls;
  logic                idle;
  logic                if_gnt;
  logic                ls_gnt;

  bus_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .if_req     (i_if_req),
    .if_flush   (i_if_flush),
    .ls_req     (i_ls_req),
    .starve_cnt (starve_cnt_reg),
    .sel_if     (sel_if),
    .sel_ls     (sel_ls)
  );

  assign idle   = (state_reg == IDLE);
  assign if_gnt = idle && sel_if && i_bus_gnt;
  assign ls_gnt = idle && sel_ls && i_bus_gnt;

  // Transaction-tracking FSM and starvation counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (if_gnt) begin
            state_reg      <= IF_PEND;
            starve_cnt_reg <= '0;
          end else if (ls_gnt) begin
            state_reg <= LS_PEND;
            if (!i_if_req)
              starve_cnt_reg <= '0;
            else if (starve_cnt_reg < STARVE_W'(STARVE_MAX))
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
          end
        end
        IF_PEND: begin
          // A response wins over a flush: the transaction is finished either way.
          if (i_bus_rvalid)
            state_reg <= IDLE;
          else if (i_if_flush)
            state_reg <= IF_DROP;
        end
        LS_PEND, IF_DROP: begin
          if (i_bus_rvalid)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Bus request muxing, grants and response steering; everything is held at 0 during reset.
  always_comb begin
    o_if_gnt    = 1'b0;
    o_ls_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_ls_rvalid = 1'b0;
    o_ls_rdata  = '0;
    o_ls_busy   = 1'b0;
    o_bus_req   = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;
    o_bus_wstrb = '0;
    if (!i_rst) begin
      o_if_gnt = if_gnt;
      o_ls_gnt = ls_gnt;
      if (idle && sel_ls) begin
        o_bus_req   = 1'b1;
        o_bus_we    = i_ls_we;
        o_bus_addr  = i_ls_addr;
        o_bus_wdata = i_ls_wdata;
        o_bus_wstrb = i_ls_wstrb;
      end else if (idle && sel_if) begin
        o_bus_req  = 1'b1;
        o_bus_addr = i_if_addr;
      end
      o_if_rvalid = (state_reg == IF_PEND) && i_bus_rvalid && !i_if_flush;
      o_ls_rvalid = (state_reg == LS_PEND) && i_bus_rvalid;
      if (o_if_rvalid)
        o_if_rdata = i_bus_rdata;
      if (o_ls_rvalid)
        o_ls_rdata = i_bus_rdata;
      o_ls_busy = i_ls_req || ((state_reg == LS_PEND) && !i_bus_rvalid);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. A transaction-level model tracks which
// master owns the bus and whether an in-flight fetch was cancelled; expected
// responses go into per-master queues that a separate monitor drains.
module tb_bus_arbiter;

  localparam int SMAX = 4;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, ls_req, ls_we, bus_gnt, bus_rvalid;
  logic [AW-1:0] if_addr, ls_addr;
  logic [31:0]   ls_wdata, bus_rdata;
  logic [3:0]    ls_wstrb;
  logic          o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_ls_busy;
  logic          o_bus_req, o_bus_we;
  logic [31:0]   o_if_rdata, o_ls_rdata, o_bus_wdata;
  logic [AW-1:0] o_bus_addr;
  logic [3:0]    o_bus_wstrb;

  bus_arbiter #(.STARVE_MAX(SMAX), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .i_ls_wstrb(ls_wstrb),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_ls_busy(o_ls_busy),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb),
    .i_bus_gnt(bus_gnt), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];

  // Reference model: who owns the bus (0 none, 1 fetch, 2 LSU), fetch cancel, starvation.
  int owner     = 0;
  bit if_cancel = 0;
  int starve    = 0;
  bit exp_if_gnt, exp_ls_gnt;
  bit dut_if_gnt_s, dut_ls_gnt_s;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called right after a falling edge with inputs already applied.
  task automatic cycle();
    int         ch;
    logic [69:0] exp_bus;
    bit         exp_busy;
    #1;
    ch = 0; exp_bus = '0; exp_busy = 0; exp_if_gnt = 0; exp_ls_gnt = 0;
    if (!rst) begin
      if (owner == 0) begin
        if (ls_req && starve < SMAX) ch = 2;
        else if (if_req && !if_flush) ch = 1;
        else if (ls_req) ch = 2;
        if (ch == 1) exp_bus = {1'b1, 1'b0, if_addr, 32'h0, 4'h0};
        if (ch == 2) exp_bus = {1'b1, ls_we, ls_addr, ls_wdata, ls_wstrb};
        exp_if_gnt = bus_gnt && (ch == 1);
        exp_ls_gnt = bus_gnt && (ch == 2);
        exp_busy   = ls_req;
      end else begin
        exp_busy = ls_req || (owner == 2 && !bus_rvalid);
        if (bus_rvalid) begin
          if (owner == 2) ls_q.push_back(bus_rdata);
          else if (owner == 1 && !if_cancel && !if_flush) if_q.push_back(bus_rdata);
        end
      end
    end
    check("grant", {o_if_gnt, o_ls_gnt}, {exp_if_gnt, exp_ls_gnt});
    check("bus_request", {o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb}, exp_bus);
    check("ls_busy", o_ls_busy, exp_busy);
    dut_if_gnt_s = o_if_gnt;
    dut_ls_gnt_s = o_ls_gnt;
    @(posedge clk);
    if (rst) begin
      owner = 0; if_cancel = 0; starve = 0;
    end else if (owner == 0) begin
      if (exp_if_gnt) begin
        owner = 1; if_cancel = 0; starve = 0;
      end else if (exp_ls_gnt) begin
        owner  = 2;
        starve = if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      end
    end else if (bus_rvalid) begin
      owner = 0;
    end else if (owner == 1 && if_flush) begin
      if_cancel = 1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit ifr, input logic [31:0] ifa, input bit fl,
                       input bit lsr, input bit we, input logic [31:0] lsa,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input bit g, input bit rv, input logic [31:0] rd);
    rst = r; if_req = ifr; if_addr = ifa; if_flush = fl;
    ls_req = lsr; ls_we = we; ls_addr = lsa; ls_wdata = wd; ls_wstrb = ws;
    bus_gnt = g; bus_rvalid = rv; bus_rdata = rd;
    cycle();
  endtask

  task automatic idle_cyc(input bit rv, input logic [31:0] rd);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rv, rd);
  endtask

  task automatic do_reset();
    drive(1, 1, 32'h44, 0, 1, 1, 32'h88, 32'h99, 4'hF, 1, 1, 32'h77);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every response the DUT presents against the queues.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (o_ls_rvalid) begin
        if (ls_q.size() == 0) check("ls_rvalid_unexpected", 1'b1, 1'b0);
        else check("ls_rdata", o_ls_rdata, ls_q.pop_front());
      end else begin
        if (ls_q.size() != 0) begin
          check("ls_rvalid_missing", 1'b0, 1'b1);
          ls_q.delete();
        end
        check("ls_rdata_idle_zero", o_ls_rdata, 32'h0);
      end
      if (o_if_rvalid) begin
        if (if_q.size() == 0) check("if_rvalid_unexpected", 1'b1, 1'b0);
        else check("if_rdata", o_if_rdata, if_q.pop_front());
      end else begin
        if (if_q.size() != 0) begin
          check("if_rvalid_missing", 1'b0, 1'b1);
          if_q.delete();
        end
        check("if_rdata_idle_zero", o_if_rdata, 32'h0);
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    int          nls;
    bit          seen_if;
    bit          lr, ir, fl, we;
    logic [31:0] la, ia, wd;
    logic [3:0]  ws;
    rst = 1; if_req = 0; if_addr = 0; if_flush = 0; ls_req = 0; ls_we = 0;
    ls_addr = 0; ls_wdata = 0; ls_wstrb = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    @(negedge clk);
    do_reset();

    // Both request at starve 0: LSU wins; load data two cycles later.
    drive(0, 1, 32'h10, 0, 1, 0, 32'h20, 0, 0, 1, 0, 0);
    check("ls_first_grant", {dut_ls_gnt_s, dut_if_gnt_s}, 2'b10);
    idle_cyc(0, 0);
    idle_cyc(1, 32'hDEADBEEF);

    // Starvation limit with both requesters pinned high and an eager bus.
    do_reset();
    nls = 0; seen_if = 0;
    repeat (12) begin
      drive(0, 1, 32'h40, 0, 1, 0, 32'h80, 0, 0, 1, (owner != 0), $urandom);
      if (!seen_if) begin
        if (dut_if_gnt_s) seen_if = 1;
        else if (dut_ls_gnt_s) nls++;
      end
    end
    check("starve_if_granted", seen_if, 1'b1);
    check("starve_ls_grants_before_if", nls, SMAX);
    while (owner != 0) idle_cyc(1, $urandom);

    // Fetch flushed while in flight: response dropped, next fetch at new address.
    do_reset();
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cyc(0, 0);
    idle_cyc(0, 0);
    idle_cyc(1, 32'h1234);
    drive(0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("flush_regrant", dut_if_gnt_s, 1'b1);
    idle_cyc(1, 32'h0BAD0200);

    // Flush coinciding with the response, then an immediate regrant.
    drive(0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h5555);
    drive(0, 1, 32'h304, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("flush_rvalid_back_to_idle", dut_if_gnt_s, 1'b1);
    idle_cyc(1, 32'h304C0DE);

    // Store: busy while requesting and waiting, released after the ack.
    drive(0, 0, 0, 0, 1, 1, 32'h400, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h400, 32'hCAFEF00D, 4'hF, 1, 0, 0);
    idle_cyc(0, 0);
    idle_cyc(1, 32'h0);
    idle_cyc(0, 0);

    // Reset while a load is outstanding, then a stray response.
    drive(0, 0, 0, 0, 1, 0, 32'h500, 0, 0, 1, 0, 0);
    do_reset();
    idle_cyc(1, 32'h5A5A5A5A);
    drive(0, 0, 0, 0, 1, 0, 32'h504, 0, 0, 1, 0, 0);
    check("post_reset_idle_grant", dut_ls_gnt_s, 1'b1);
    idle_cyc(1, 32'h504);

    // Randomized traffic; requesters hold their request until granted.
    lr = 0; ir = 0; la = 0; ia = 0; wd = 0; ws = 0; we = 0;
    repeat (1500) begin
      if (!lr) begin
        lr = ($urandom_range(0, 1) == 1);
        la = $urandom; wd = $urandom; ws = 4'($urandom); we = ($urandom_range(0, 1) == 1);
      end
      fl = ($urandom_range(0, 7) == 0);
      if (!ir || fl) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = $urandom;
      end
      drive(($urandom_range(0, 149) == 0), ir, ia, fl, lr, we, la, wd, ws,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom);
      if (exp_ls_gnt) lr = 0;
      if (exp_if_gnt) ir = 0;
    end
    idle_cyc(0, 0);
    idle_cyc(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive LSU grants while IF is waiting.
REQ-002 SHALL have parameter ADDR_W, default 32: bus address width.
REQ-003 SHALL have ports, clock and reset first:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_if_req  in  1  instruction-fetch read request.
- i_if_addr  in  ADDR_W  fetch address.
- i_if_flush  in  1  jump flush; cancels the current or pending fetch.
- o_if_gnt  out  1  fetch accepted by the bus.
- o_if_rvalid  out  1  fetch data valid.
- o_if_rdata  out  32  fetch data.
- i_ls_req  in  1  load/store request.
- i_ls_we  in  1  1 = store.
- i_ls_addr  in  ADDR_W  load/store address.
- i_ls_wdata  in  32  store data.
- i_ls_wstrb  in  4  byte strobes.
- o_ls_gnt  out  1  load/store accepted.
- o_ls_rvalid  out  1  load data valid, or store acknowledge.
- o_ls_rdata  out  32  load data.
- o_ls_busy  out  1  stall request to pipeline control.
- o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb  out  1/1/ADDR_W/32/4  shared memory port request.
- i_bus_gnt  in  1  bus accepts the request this cycle.
- i_bus_rvalid  in  1  response valid.
- i_bus_rdata  in  32  response data.

Function
REQ-004 SHALL implement FSM states IDLE, IF_PEND, LS_PEND and IF_DROP, with at most one outstanding bus transaction.
REQ-005 In IDLE, SHALL select LSU if i_ls_req=1 and starve_cnt<STARVE_MAX; otherwise SHALL select IF if i_if_req=1 and i_if_flush=0; otherwise SHALL select LSU if i_ls_req=1.
REQ-006 In IDLE, SHALL drive o_bus_* combinationally from the selected requester; o_bus_req=0 and o_bus_we=0 when nothing is selected.
REQ-007 SHALL drive o_if_gnt/o_ls_gnt = i_bus_gnt AND (that requester selected) AND state==IDLE; never both in one cycle.
REQ-008 On a grant, SHALL move to IF_PEND or LS_PEND; o_bus_req=0 in every non-IDLE state.
REQ-009 In X_PEND with i_bus_rvalid=1, SHALL pulse o_X_rvalid for 1 cycle with o_X_rdata=i_bus_rdata, then go to IDLE; the next grant is no earlier than the following cycle.
REQ-010 In IF_PEND with i_if_flush=1 and i_bus_rvalid=0, SHALL go to IF_DROP.
REQ-011 In IF_PEND with i_if_flush=1 and i_bus_rvalid=1, SHALL hold o_if_rvalid=0 and go to IDLE.
REQ-012 In IF_DROP, SHALL discard the response (o_if_rvalid=0) and go to IDLE on i_bus_rvalid; further flushes have no effect.
REQ-013 In IDLE, SHALL ignore i_bus_rvalid (stray response after reset); no rvalid output.
REQ-014 starve_cnt, 3 bits, SHALL:
- increment, saturating at STARVE_MAX, on each LSU grant with i_if_req=1;
- clear on any IF grant;
- clear on an LSU grant with i_if_req=0.
REQ-015 SHALL drive o_ls_busy = i_ls_req OR (state==LS_PEND AND NOT i_bus_rvalid), combinationally.
REQ-016 SHALL hold o_if_rdata/o_ls_rdata at 0 when the matching rvalid is 0.
REQ-017 SHALL leave requester inputs uncaptured; requesters hold them stable until their grant.

Reset
REQ-018 On i_rst=1, asynchronously: state=IDLE, starve_cnt=0.
REQ-019 While i_rst=1, SHALL drive all outputs to 0.
REQ-020 Reset mid-transaction SHALL abandon the outstanding transaction with no rvalid emitted.

Structure
REQ-021 SHALL place state encodings (2 bits: IDLE=0, IF_PEND=1, LS_PEND=2, IF_DROP=3) and the STARVE_MAX default in the shared core defines header.
REQ-022 SHALL contain a single sub-module, bus_arb_pick: combinational selection per REQ-005, outputs sel_if and sel_ls.

Verification
REQ-023 LSU and IF both request in IDLE with starve_cnt=0, gnt=1 -> o_ls_gnt=1, o_if_gnt=0; rvalid with rdata=0xDEADBEEF 2 cycles later -> o_ls_rvalid=1, o_ls_rdata=0xDEADBEEF.
REQ-024 i_ls_req and i_if_req held high, gnt and rvalid immediate -> exactly 4 LSU grants, then 1 IF grant, then starve_cnt=0.
REQ-025 IF granted at addr 0x100, i_if_flush=1 one cycle later, rvalid 3 cycles later -> o_if_rvalid stays 0; next IF grant at new addr 0x200.
REQ-026 Flush coincident with rvalid in IF_PEND -> no o_if_rvalid; state IDLE next cycle.
REQ-027 Store (we=1, wstrb=0xF) -> o_ls_busy high from request until the ack cycle, low the cycle after.
REQ-028 i_rst asserted in LS_PEND, then stray rvalid after release -> no rvalid output; state IDLE.
